// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard/flush control for the 5-stage rv64 pipeline: D-stage
//               forwarding selects and stalls, redirect/trap flushes, and the
//               multi-cycle MDU launch sequencer for the op held in regE.
//               Optional perf counters built when PIPE_HAZARD_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regD_valid,
    input  logic [REG_AW-1:0] regD_rs1,
    input  logic [REG_AW-1:0] regD_rs2,
    input  logic              regD_rs1_ren,
    input  logic              regD_rs2_ren,
    input  logic              regE_valid,
    input  logic [REG_AW-1:0] regE_rd,
    input  logic              regE_wen,
    input  logic              regE_is_load,
    input  logic              regE_is_mdu,
    input  logic              regE_redirect,
    input  logic              mdu_done,
    input  logic              regM_valid,
    input  logic [REG_AW-1:0] regM_rd,
    input  logic              regM_wen,
    input  logic              regM_is_load,
    input  logic              regM_trap,
    input  logic              regM_allow_in,
    input  logic              regW_valid,
    input  logic [REG_AW-1:0] regW_rd,
    input  logic              regW_wen,
    output logic              regD_ready_go,
    output logic              regE_ready_go,
    output logic              mdu_start,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic              flush_F,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic [PERF_W-1:0] perf_lu_stall,
    output logic [PERF_W-1:0] perf_mdu_stall,
    output logic [PERF_W-1:0] perf_flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } mdu_state_e;

    mdu_state_e state_q, state_d;

    logic e_m1, e_m2, m_m1, m_m2, w_m1, w_m2;
    logic trap, redirect, mdu_in_e;
    logic lu_stall, mdu_stall;

    function automatic logic prod_match(input logic v, input logic wen,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs,
                                        input logic ren);
        return v && wen && (rd != '0) && (rd == rs) && ren;
    endfunction

    always_comb begin
        e_m1 = prod_match(regE_valid, regE_wen, regE_rd, regD_rs1, regD_rs1_ren);
        e_m2 = prod_match(regE_valid, regE_wen, regE_rd, regD_rs2, regD_rs2_ren);
        m_m1 = prod_match(regM_valid, regM_wen, regM_rd, regD_rs1, regD_rs1_ren);
        m_m2 = prod_match(regM_valid, regM_wen, regM_rd, regD_rs2, regD_rs2_ren);
        w_m1 = prod_match(regW_valid, regW_wen, regW_rd, regD_rs1, regD_rs1_ren);
        w_m2 = prod_match(regW_valid, regW_wen, regW_rd, regD_rs2, regD_rs2_ren);

        fwd_rs1_sel = e_m1 ? 2'd1 : m_m1 ? 2'd2 : w_m1 ? 2'd3 : 2'd0;
        fwd_rs2_sel = e_m2 ? 2'd1 : m_m2 ? 2'd2 : w_m2 ? 2'd3 : 2'd0;

        // Load data only becomes forwardable once it reaches W.
        lu_stall  = ((e_m1 || e_m2) && regE_is_load) ||
                    ((m_m1 || m_m2) && regM_is_load);
        mdu_stall = (e_m1 || e_m2) && regE_is_mdu && (state_q != DONE);

        mdu_in_e      = regE_valid && regE_is_mdu;
        regE_ready_go = !mdu_in_e || (state_q == DONE);

        trap     = regM_valid && regM_trap;
        redirect = regE_valid && regE_ready_go && regE_redirect;
        flush_F  = trap || redirect;
        flush_D  = trap || redirect;
        flush_E  = trap;
        flush_M  = trap;

        regD_ready_go = flush_D || !(lu_stall || mdu_stall);
    end

    always_comb begin
        state_d   = state_q;
        mdu_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu_in_e && !flush_E) begin
                    mdu_start = rst;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (flush_E)       state_d = mdu_done ? IDLE : DRAIN;
                else if (mdu_done) state_d = DONE;
            end
            DONE: begin
                if (flush_E || regM_allow_in) state_d = IDLE;
            end
            DRAIN: begin
                if (mdu_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [PERF_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [PERF_W-1:0] fl_cnt_q, fl_cnt_d;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                  input logic en);
        return (en && (v != '1)) ? v + PERF_W'(1) : v;
    endfunction

    always_comb begin
        lu_cnt_d  = sat_inc(lu_cnt_q, regD_valid && lu_stall && !flush_D);
        mdu_cnt_d = sat_inc(mdu_cnt_q, (state_q == BUSY) || (state_q == DRAIN));
        fl_cnt_d  = sat_inc(fl_cnt_q, trap || redirect);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt_q  <= '0;
            mdu_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    assign perf_lu_stall  = lu_cnt_q;
    assign perf_mdu_stall = mdu_cnt_q;
    assign perf_flush     = fl_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = regD_valid;
    assign perf_lu_stall  = '0;
    assign perf_mdu_stall = '0;
    assign perf_flush     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Randomized self-checking bench for pipe_hazard_ctrl against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int PERF_W = 32;
    localparam int N_CYC  = 4000;

    logic clk = 1'b0;
    logic rst;
    logic regD_valid, regD_rs1_ren, regD_rs2_ren;
    logic [REG_AW-1:0] regD_rs1, regD_rs2, regE_rd, regM_rd, regW_rd;
    logic regE_valid, regE_wen, regE_is_load, regE_is_mdu, regE_redirect, mdu_done;
    logic regM_valid, regM_wen, regM_is_load, regM_trap, regM_allow_in;
    logic regW_valid, regW_wen;
    logic regD_ready_go, regE_ready_go, mdu_start;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic flush_F, flush_D, flush_E, flush_M;
    logic [PERF_W-1:0] perf_lu_stall, perf_mdu_stall, perf_flush;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: MDU progress as three independent facts about the op.
    bit m_busy, m_done, m_drain;
    longint m_lu, m_mdu, m_fl;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .regD_valid(regD_valid), .regD_rs1(regD_rs1), .regD_rs2(regD_rs2),
        .regD_rs1_ren(regD_rs1_ren), .regD_rs2_ren(regD_rs2_ren),
        .regE_valid(regE_valid), .regE_rd(regE_rd), .regE_wen(regE_wen),
        .regE_is_load(regE_is_load), .regE_is_mdu(regE_is_mdu),
        .regE_redirect(regE_redirect), .mdu_done(mdu_done),
        .regM_valid(regM_valid), .regM_rd(regM_rd), .regM_wen(regM_wen),
        .regM_is_load(regM_is_load), .regM_trap(regM_trap),
        .regM_allow_in(regM_allow_in),
        .regW_valid(regW_valid), .regW_rd(regW_rd), .regW_wen(regW_wen),
        .regD_ready_go(regD_ready_go), .regE_ready_go(regE_ready_go),
        .mdu_start(mdu_start), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .flush_F(flush_F), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .perf_lu_stall(perf_lu_stall), .perf_mdu_stall(perf_mdu_stall),
        .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_match(input bit v, input bit w, input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs, input bit ren);
        return v && w && (rd != 0) && (rd == rs) && ren;
    endfunction

    // Source for an operand: 0 regfile, else 1+index of the youngest matching producer.
    function automatic int exp_sel(input logic [REG_AW-1:0] rs, input bit ren);
        bit v[3];
        bit w[3];
        logic [REG_AW-1:0] rd[3];
        v[0] = regE_valid; w[0] = regE_wen; rd[0] = regE_rd;
        v[1] = regM_valid; w[1] = regM_wen; rd[1] = regM_rd;
        v[2] = regW_valid; w[2] = regW_wen; rd[2] = regW_rd;
        for (int i = 0; i < 3; i++)
            if (is_match(v[i], w[i], rd[i], rs, ren)) return i + 1;
        return 0;
    endfunction

    function automatic bit any_match_e();
        return is_match(regE_valid, regE_wen, regE_rd, regD_rs1, regD_rs1_ren) ||
               is_match(regE_valid, regE_wen, regE_rd, regD_rs2, regD_rs2_ren);
    endfunction

    function automatic bit any_match_m();
        return is_match(regM_valid, regM_wen, regM_rd, regD_rs1, regD_rs1_ren) ||
               is_match(regM_valid, regM_wen, regM_rd, regD_rs2, regD_rs2_ren);
    endfunction

    function automatic bit exp_trap();
        return regM_valid && regM_trap;
    endfunction

    function automatic bit exp_e_go();
        return !(regE_valid && regE_is_mdu) || m_done;
    endfunction

    function automatic bit exp_redirect();
        return regE_valid && exp_e_go() && regE_redirect;
    endfunction

    function automatic bit exp_lu();
        return (any_match_e() && regE_is_load) || (any_match_m() && regM_is_load);
    endfunction

    task automatic model_clear();
        m_busy = 0; m_done = 0; m_drain = 0;
        m_lu = 0; m_mdu = 0; m_fl = 0;
    endtask

    task automatic check_outputs();
        bit idle, trap, fl_d, stall;
        idle  = !(m_busy || m_done || m_drain);
        trap  = exp_trap();
        fl_d  = trap || exp_redirect();
        stall = exp_lu() || (any_match_e() && regE_is_mdu && !m_done);
        check_eq("fwd_rs1_sel", fwd_rs1_sel, exp_sel(regD_rs1, regD_rs1_ren));
        check_eq("fwd_rs2_sel", fwd_rs2_sel, exp_sel(regD_rs2, regD_rs2_ren));
        if (!fl_d) check_eq("regD_ready_go", regD_ready_go, !stall);
        check_eq("regE_ready_go", regE_ready_go, exp_e_go());
        check_eq("mdu_start", mdu_start,
                 rst && idle && regE_valid && regE_is_mdu && !trap);
        check_eq("flush_F", flush_F, fl_d);
        check_eq("flush_D", flush_D, fl_d);
        check_eq("flush_E", flush_E, trap);
        check_eq("flush_M", flush_M, trap);
`ifdef PIPE_HAZARD_PERF_EN
        check_eq("perf_lu_stall", perf_lu_stall, m_lu);
        check_eq("perf_mdu_stall", perf_mdu_stall, m_mdu);
        check_eq("perf_flush", perf_flush, m_fl);
`else
        check_eq("perf_lu_stall", perf_lu_stall, 0);
        check_eq("perf_mdu_stall", perf_mdu_stall, 0);
        check_eq("perf_flush", perf_flush, 0);
`endif
    endtask

    // Advance the model over one rising edge using the inputs held across it.
    task automatic model_step();
        bit idle, trap, nb, nd, ndr, fl_d;
        if (!rst) begin
            model_clear();
            return;
        end
        idle = !(m_busy || m_done || m_drain);
        trap = exp_trap();
        fl_d = trap || exp_redirect();
        if (regD_valid && exp_lu() && !fl_d) m_lu++;
        if (m_busy || m_drain) m_mdu++;
        if (fl_d) m_fl++;
        nb = m_busy; nd = m_done; ndr = m_drain;
        if (idle && regE_valid && regE_is_mdu && !trap) nb = 1;
        if (m_busy) begin
            if (trap) begin
                nb  = 0;
                ndr = !mdu_done;
            end else if (mdu_done) begin
                nb = 0;
                nd = 1;
            end
        end
        if (m_done && (trap || regM_allow_in)) nd = 0;
        if (m_drain && mdu_done) ndr = 0;
        m_busy = nb; m_done = nd; m_drain = ndr;
    endtask

    task automatic drive_idle();
        regD_valid = 0; regD_rs1 = 0; regD_rs2 = 0; regD_rs1_ren = 0; regD_rs2_ren = 0;
        regE_valid = 0; regE_rd = 0; regE_wen = 0; regE_is_load = 0; regE_is_mdu = 0;
        regE_redirect = 0; mdu_done = 0;
        regM_valid = 0; regM_rd = 0; regM_wen = 0; regM_is_load = 0; regM_trap = 0;
        regM_allow_in = 0;
        regW_valid = 0; regW_rd = 0; regW_wen = 0;
    endtask

    task automatic drive_random();
        bit waiting;
        waiting       = m_busy || m_drain;
        regD_valid    = ($urandom_range(0, 3) != 0);
        regD_rs1      = REG_AW'($urandom_range(0, 3));
        regD_rs2      = REG_AW'($urandom_range(0, 3));
        regD_rs1_ren  = ($urandom_range(0, 3) != 0);
        regD_rs2_ren  = ($urandom_range(0, 3) != 0);
        regE_valid    = ($urandom_range(0, 3) != 0);
        regE_rd       = REG_AW'($urandom_range(0, 3));
        regE_wen      = ($urandom_range(0, 2) != 0);
        regE_is_load  = ($urandom_range(0, 4) == 0);
        regE_is_mdu   = waiting ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
        regE_redirect = ($urandom_range(0, 3) == 0);
        mdu_done      = waiting ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
        regM_valid    = ($urandom_range(0, 3) != 0);
        regM_rd       = REG_AW'($urandom_range(0, 3));
        regM_wen      = ($urandom_range(0, 2) != 0);
        regM_is_load  = ($urandom_range(0, 3) == 0);
        regM_trap     = ($urandom_range(0, 11) == 0);
        regM_allow_in = ($urandom_range(0, 1) != 0);
        regW_valid    = ($urandom_range(0, 3) != 0);
        regW_rd       = REG_AW'($urandom_range(0, 3));
        regW_wen      = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_clear();
        #2;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < N_CYC; c++) begin
            drive_random();
            // Occasional asynchronous reset pulses land mid-cycle, often mid-BUSY.
            rst = ($urandom_range(0, 79) != 0);
            if (!rst) model_clear();
            #4;
            check_outputs();
            @(posedge clk);
            model_step();
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
